// File: rtl/load_size_unit_pkg.sv
// Shared load/store sizing definitions: size encodings, FSM state encodings
// and the latched request record used by the load and store size blocks.
package load_size_unit_pkg;

   typedef logic [1:0] ls_size_t;
   typedef logic [1:0] fsm_state_t;

   localparam ls_size_t LS_WORD = 2'b00;
   localparam ls_size_t LS_BYTE = 2'b01;
   localparam ls_size_t LS_HALF = 2'b10;
   localparam ls_size_t LS_RSVD = 2'b11;

   localparam fsm_state_t ST_IDLE = 2'b00;
   localparam fsm_state_t ST_READ = 2'b01;
   localparam fsm_state_t ST_WAIT = 2'b10;
   localparam fsm_state_t ST_DONE = 2'b11;

   localparam int CNT_W = 3;

   typedef struct packed {
      ls_size_t size;
      logic     sign_ext;
   } ls_req_t;

endpackage

// File: rtl/load_size_unit_ls_extend.sv
// Sub-word extraction and sign/zero extension of a loaded memory word.
// The reserved size code falls through to a full-word load.
module ls_extend
   import load_size_unit_pkg::*;
(
   input  logic [31:0] word,
   input  ls_size_t    size,
   input  logic        sign_ext,
   output logic [31:0] ls_out
);

   always_comb begin
      ls_out = word;
      case (size)
         LS_BYTE: ls_out = {{24{sign_ext & word[7]}}, word[7:0]};
         LS_HALF: ls_out = {{16{sign_ext & word[15]}}, word[15:0]};
         default: ls_out = word;
      endcase
   end

endmodule

// File: rtl/load_size_unit.sv
// Load sequencer: issues one memory read, waits the fixed memory latency,
// then presents the size-adjusted result and the raw word.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for start; request latched on acceptance
//   READ    | mem_rd asserted for this single cycle
//   WAIT    | down-counting memory latency; capture at terminal count
//   DONE    | done pulse; results already registered
module load_size_unit
   import load_size_unit_pkg::*;
#(
   parameter int MEM_LATENCY = 2
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  controleLS,
   input  logic        sign_ext,
   output logic        mem_rd,
   input  logic [31:0] mem_data,
   output logic [31:0] ls_out,
   output logic [31:0] ls_word,
   output logic        busy,
   output logic        done
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

   fsm_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ls_req_t          req_q, req_d;
   logic [31:0]      ls_out_q, ls_out_d;
   logic [31:0]      ls_word_q, ls_word_d;
   logic [31:0]      ext_out;

   ls_extend u_ls_extend (
      .word     (mem_data),
      .size     (req_q.size),
      .sign_ext (req_q.sign_ext),
      .ls_out   (ext_out)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      ls_out_d  = ls_out_q;
      ls_word_d = ls_word_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               req_d.size     = controleLS;
               req_d.sign_ext = sign_ext;
               state_d        = ST_READ;
            end
         end
         ST_READ: begin
            cnt_d   = LAT_M1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // terminal count lines up with the cycle mem_data is valid
            if (cnt_q == '0) begin
               ls_word_d = mem_data;
               ls_out_d  = ext_out;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         ls_out_q  <= '0;
         ls_word_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         ls_out_q  <= ls_out_d;
         ls_word_q <= ls_word_d;
      end
   end

   assign mem_rd  = (state_q == ST_READ);
   assign done    = (state_q == ST_DONE);
   assign busy    = (state_q != ST_IDLE);
   assign ls_out  = ls_out_q;
   assign ls_word = ls_word_q;

endmodule
